// File: rtl/coeff_seq_ctrl.sv
// rtl/coeff_seq_ctrl.sv - coefficient FIFO load/replay sequencer with aligned index/last tags
module coeff_seq_ctrl #(
   parameter int                   RAM_WIDTH  = 32,
   parameter int                   ADDR_LINES = 12,
   parameter logic [RAM_WIDTH-1:0] START_WORD = 32'h7F900000,
   parameter int                   RD_LATENCY = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_coeff_valid_i,
   input  logic [RAM_WIDTH-1:0]  s_coeff_data_i,
   output logic                  s_coeff_ready_o,
   output logic                  fifo_wr_en_o,
   output logic [RAM_WIDTH-1:0]  fifo_data_o,
   input  logic                  fifo_full_i,
   output logic                  fifo_rd_en_o,
   output logic                  fifo_redo_o,
   output logic                  fifo_clr_o,
   input  logic                  eval_req_i,
   output logic                  eval_busy_o,
   output logic                  eval_done_o,
   input  logic                  clear_i,
   output logic                  coeff_valid_o,
   output logic [ADDR_LINES-1:0] coeff_idx_o,
   output logic                  coeff_last_o,
   output logic [ADDR_LINES:0]   ncoeff_o,
   output logic                  err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_EVAL,
      S_REWIND,
      S_ERROR
   } state_t;

   localparam logic [7:0] DRAIN_LAST = 8'(RD_LATENCY - 1);

   state_t                state_q, state_d;
   logic [ADDR_LINES:0]   ncoeff_q, ncoeff_d;
   logic [ADDR_LINES-1:0] rc_q, rc_d;
   logic [7:0]            drain_q, drain_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;

   logic                  is_start;
   logic                  last_rd;
   logic                  ready;
   logic                  wr_en;
   logic                  rd_en;
   logic                  redo;
   logic                  clr;

   logic [RD_LATENCY-1:0] vld_pipe_q;
   logic [RD_LATENCY-1:0] last_pipe_q;
   logic [ADDR_LINES-1:0] idx_pipe_q [RD_LATENCY];

   assign is_start = (s_coeff_data_i == START_WORD);
   // rc is compared one bit wider so a full set of 2^ADDR_LINES words still terminates
   assign last_rd  = ({1'b0, rc_q} == (ncoeff_q - 1'b1));

   // State and bookkeeping registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         ncoeff_q <= '0;
         rc_q     <= '0;
         drain_q  <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ncoeff_q <= ncoeff_d;
         rc_q     <= rc_d;
         drain_q  <= drain_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   // Next-state and FIFO control decode; clear beats any same-cycle handshake
   always_comb begin
      state_d  = state_q;
      ncoeff_d = ncoeff_q;
      rc_d     = rc_q;
      drain_d  = drain_q;
      err_d    = err_q;
      done_d   = 1'b0;
      ready    = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      redo     = 1'b0;
      clr      = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (clear_i) begin
               clr      = 1'b1;
               state_d  = S_IDLE;
               ncoeff_d = '0;
               err_d    = 1'b0;
            end else begin
               ready = ~fifo_full_i | is_start;
               if (s_coeff_valid_i && ready) begin
                  if (is_start) begin
                     if (state_q == S_IDLE) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                     end else begin
                        state_d = S_READY;
                     end
                  end else begin
                     wr_en    = 1'b1;
                     ncoeff_d = ncoeff_q + 1'b1;
                     state_d  = S_LOAD;
                  end
               end
            end
         end
         S_READY: begin
            if (clear_i) begin
               clr      = 1'b1;
               state_d  = S_IDLE;
               ncoeff_d = '0;
               err_d    = 1'b0;
            end else if (eval_req_i) begin
               state_d = S_EVAL;
               rc_d    = '0;
            end
         end
         S_EVAL: begin
            rd_en = 1'b1;
            if (last_rd) begin
               state_d = S_REWIND;
               drain_d = '0;
            end else begin
               rc_d = rc_q + 1'b1;
            end
         end
         S_REWIND: begin
            redo = (drain_q == 8'd0);
            if (drain_q == DRAIN_LAST) begin
               state_d = S_READY;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 8'd1;
            end
         end
         S_ERROR: begin
            if (clear_i) begin
               clr      = 1'b1;
               state_d  = S_IDLE;
               ncoeff_d = '0;
               err_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Delay read tags by the FIFO read latency so they line up with FIFO data_o
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            idx_pipe_q[k] <= '0;
         end
      end else begin
         vld_pipe_q[0]  <= rd_en;
         last_pipe_q[0] <= rd_en & last_rd;
         idx_pipe_q[0]  <= rd_en ? rc_q : '0;
         for (int k = 1; k < RD_LATENCY; k++) begin
            vld_pipe_q[k]  <= vld_pipe_q[k-1];
            last_pipe_q[k] <= last_pipe_q[k-1];
            idx_pipe_q[k]  <= idx_pipe_q[k-1];
         end
      end
   end

   assign s_coeff_ready_o = ready;
   assign fifo_wr_en_o    = wr_en;
   assign fifo_data_o     = s_coeff_data_i;
   assign fifo_rd_en_o    = rd_en;
   assign fifo_redo_o     = redo;
   assign fifo_clr_o      = clr;
   assign eval_busy_o     = (state_q == S_EVAL) || (state_q == S_REWIND);
   assign eval_done_o     = done_q;
   assign coeff_valid_o   = vld_pipe_q[RD_LATENCY-1];
   assign coeff_last_o    = last_pipe_q[RD_LATENCY-1];
   assign coeff_idx_o     = idx_pipe_q[RD_LATENCY-1];
   assign ncoeff_o        = ncoeff_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// tb/tb_coeff_seq_ctrl.sv - scoreboard bench for coeff_seq_ctrl with FIFO model
module tb_coeff_seq_ctrl;

   localparam int          RW = 32;
   localparam int          AL = 12;
   localparam int          RL = 2;
   localparam logic [31:0] SW = 32'h7F900000;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic [RW-1:0] s_data;
   logic          s_ready;
   logic          fifo_wr_en;
   logic [RW-1:0] fifo_data;
   logic          fifo_full;
   logic          fifo_rd_en;
   logic          fifo_redo;
   logic          fifo_clr;
   logic          eval_req;
   logic          eval_busy;
   logic          eval_done;
   logic          clear;
   logic          coeff_valid;
   logic [AL-1:0] coeff_idx;
   logic          coeff_last;
   logic [AL:0]   ncoeff;
   logic          err;

   always #5 clk = ~clk;

   coeff_seq_ctrl #(
      .RAM_WIDTH (RW),
      .ADDR_LINES(AL),
      .START_WORD(SW),
      .RD_LATENCY(RL)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .s_coeff_valid_i(s_valid),
      .s_coeff_data_i (s_data),
      .s_coeff_ready_o(s_ready),
      .fifo_wr_en_o   (fifo_wr_en),
      .fifo_data_o    (fifo_data),
      .fifo_full_i    (fifo_full),
      .fifo_rd_en_o   (fifo_rd_en),
      .fifo_redo_o    (fifo_redo),
      .fifo_clr_o     (fifo_clr),
      .eval_req_i     (eval_req),
      .eval_busy_o    (eval_busy),
      .eval_done_o    (eval_done),
      .clear_i        (clear),
      .coeff_valid_o  (coeff_valid),
      .coeff_idx_o    (coeff_idx),
      .coeff_last_o   (coeff_last),
      .ncoeff_o       (ncoeff),
      .err_o          (err)
   );

   // FIFO model: write pointer, rewindable read pointer, two-cycle read data
   logic [31:0] mem [4096];
   int          wptr = 0;
   int          rptr = 0;
   int          wr_cnt = 0;
   logic [31:0] d1, d2;

   always @(posedge clk) begin
      if (rst || fifo_clr) begin
         wptr <= 0;
         rptr <= 0;
      end else begin
         if (fifo_wr_en) begin
            mem[wptr[11:0]] <= fifo_data;
            wptr   <= wptr + 1;
            wr_cnt <= wr_cnt + 1;
         end
         if (fifo_redo) rptr <= 0;
         else if (fifo_rd_en) rptr <= rptr + 1;
      end
      d1 <= mem[rptr[11:0]];
      d2 <= d1;
   end

   typedef struct {
      int          idx;
      bit          last;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model_set[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int redo_cnt = 0;
   int done_cnt = 0;
   int last_vld_cyc = -10;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // One full replay of the stored set is expected per accepted request
   function automatic void push_replay();
      exp_t e;
      for (int i = 0; i < model_set.size(); i++) begin
         e.idx  = i;
         e.last = (i == model_set.size() - 1);
         e.data = model_set[i];
         sbq.push_back(e);
      end
   endfunction

   // Monitor: pop one expected entry per presented coefficient
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         if (fifo_rd_en) rd_cnt++;
         if (fifo_redo) redo_cnt++;
         if (coeff_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_coeff", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("coeff_idx", coeff_idx, e.idx);
               chk("coeff_last", coeff_last, e.last);
               chk("coeff_data", d2, e.data);
            end
            if (coeff_last) last_vld_cyc = cyc;
         end
         if (eval_done) begin
            done_cnt++;
            chk("done_after_last", cyc, last_vld_cyc + 1);
         end
      end
   end

   task automatic send_word(input logic [31:0] w, input bit stalls);
      bit ok = 0;
      int tries = 0;
      while (!ok && tries < 200) begin
         @(negedge clk);
         tries++;
         if (stalls && $urandom_range(0, 3) == 0) begin
            s_valid   = 1'b0;
            fifo_full = 1'($urandom_range(0, 1));
         end else begin
            s_valid   = 1'b1;
            s_data    = w;
            fifo_full = stalls ? ($urandom_range(0, 2) == 0) : 1'b0;
            #1;
            if (s_ready) ok = 1;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic load_set(input bit stalls);
      for (int i = 0; i < model_set.size(); i++) send_word(model_set[i], stalls);
      send_word(SW, stalls);
      @(negedge clk);
      s_valid   = 1'b0;
      fifo_full = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t = 0;
      while (done_cnt < target && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("done_seen", done_cnt >= target, 1);
   endtask

   task automatic eval_once();
      int rd0 = rd_cnt;
      int rdo0 = redo_cnt;
      int dn0 = done_cnt;
      push_replay();
      @(negedge clk);
      eval_req = 1'b1;
      @(negedge clk);
      eval_req = 1'b0;
      wait_done(dn0 + 1);
      chk("once_rd_cycles", rd_cnt - rd0, model_set.size());
      chk("once_redo", redo_cnt - rdo0, 1);
      chk("once_sb_empty", sbq.size(), 0);
   endtask

   task automatic eval_hold(input int n);
      int rd0 = rd_cnt;
      int rdo0 = redo_cnt;
      int dn0 = done_cnt;
      int k = 0;
      int t = 0;
      int prev = 0;
      for (int i = 0; i < n; i++) push_replay();
      @(negedge clk);
      eval_req = 1'b1;
      while (k < n && t < 500) begin
         @(negedge clk);
         t++;
         if (eval_done) begin
            k++;
            if (k > 1) chk("replay_period", t - prev, model_set.size() + RL + 1);
            prev = t;
            if (k == n) eval_req = 1'b0;
         end
      end
      eval_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_done", done_cnt - dn0, n);
      chk("hold_redo", redo_cnt - rdo0, n);
      chk("hold_rd_cycles", rd_cnt - rd0, n * model_set.size());
      chk("hold_sb_empty", sbq.size(), 0);
      chk("hold_idle_busy", eval_busy, 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      #1;
      chk("clr_pulse", fifo_clr, 1);
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("clr_ncoeff", ncoeff, 0);
      chk("clr_err", err, 0);
      chk("clr_ready_idle", s_ready, 1);
   endtask

   task automatic set_directed();
      model_set.delete();
      model_set.push_back(32'h3F800000);
      model_set.push_back(32'h40000000);
      model_set.push_back(32'h40400000);
      model_set.push_back(32'h40800000);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int w0, k, n, r;
      logic [31:0] w;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;
      eval_req = 1'b0; clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", s_ready, 1);
      chk("rst_ncoeff", ncoeff, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", eval_busy, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", coeff_valid, 0);
      chk("rst_done", eval_done, 0);
      rst = 1'b0;

      // eval request in IDLE is ignored
      @(negedge clk); eval_req = 1'b1;
      @(negedge clk); eval_req = 1'b0;
      @(negedge clk);
      chk("idle_eval_ignored", eval_busy, 0);
      chk("idle_no_reads", rd_cnt, 0);

      // clear wins over a same-cycle handshake
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h3F800000; clear = 1'b1;
      #1;
      chk("clr_hs_ready", s_ready, 0);
      chk("clr_hs_wr", fifo_wr_en, 0);
      @(negedge clk);
      s_valid = 1'b0; clear = 1'b0;
      chk("clr_hs_no_write", wr_cnt, 0);

      // directed load and replays
      set_directed();
      w0 = wr_cnt;
      load_set(0);
      @(negedge clk);
      chk("load_writes", wr_cnt - w0, 4);
      chk("load_ncoeff", ncoeff, 4);
      chk("load_err", err, 0);
      chk("load_ready_low", s_ready, 0);
      eval_once();
      eval_hold(3);

      // full stalls data words but not START_WORD
      do_clear();
      model_set.delete();
      model_set.push_back(32'h3F800000);
      w0 = wr_cnt;
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h3F800000; fifo_full = 1'b1;
      #1;
      chk("full_ready", s_ready, 0);
      chk("full_wr", fifo_wr_en, 0);
      repeat (3) @(negedge clk);
      chk("full_no_write", wr_cnt - w0, 0);
      fifo_full = 1'b0;
      #1;
      chk("unfull_ready", s_ready, 1);
      @(negedge clk);
      s_data = SW; fifo_full = 1'b1;
      #1;
      chk("full_start_ready", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0; fifo_full = 1'b0;
      chk("full_one_write", wr_cnt - w0, 1);
      chk("full_ncoeff", ncoeff, 1);
      eval_once();

      // START_WORD first gives ERROR
      do_clear();
      w0 = wr_cnt;
      send_word(SW, 0);
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      chk("err_set", err, 1);
      chk("err_no_write", wr_cnt - w0, 0);
      chk("err_ready_low", s_ready, 0);
      do_clear();

      // reset in the middle of a replay
      set_directed();
      load_set(0);
      push_replay();
      r = redo_cnt;
      @(negedge clk); eval_req = 1'b1;
      @(negedge clk); eval_req = 1'b0;
      k = 0;
      for (int t = 0; t < 20; t++) begin
         if (fifo_rd_en) k++;
         if (k == 3) break;
         @(negedge clk);
      end
      chk("rst_mid_reach_rc2", k, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_rd_en", fifo_rd_en, 0);
      chk("rst_mid_redo", fifo_redo, 0);
      chk("rst_mid_busy", eval_busy, 0);
      chk("rst_mid_valid", coeff_valid, 0);
      chk("rst_mid_ncoeff", ncoeff, 0);
      sbq.delete();
      repeat (4) @(negedge clk);
      chk("rst_mid_no_redo", redo_cnt - r, 0);

      // randomized loads and replays
      repeat (6) begin
         do_clear();
         n = $urandom_range(1, 8);
         model_set.delete();
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == SW) w = w ^ 32'h1;
            model_set.push_back(w);
         end
         load_set(1);
         @(negedge clk);
         chk("rnd_ncoeff", ncoeff, n);
         chk("rnd_err", err, 0);
         r = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 1) eval_hold(r);
         else repeat (r) eval_once();
      end

      repeat (5) @(negedge clk);
      chk("final_sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
